// File: rtl/seg7_scan_gen.sv
// Multiplexed 7-segment scanner: double-buffered digit data, hex glyphs,
// per-digit decimal point and blink, optional leading-zero blanking.
module seg7_scan_gen #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_DIV      = 10000,
  parameter int unsigned BLINK_FRAMES = 312
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      load,
  input  logic                      blank_en,
  input  logic                      hex_en,
  output logic                      a,
  output logic                      b,
  output logic                      c,
  output logic                      d,
  output logic                      e,
  output logic                      f,
  output logic                      g,
  output logic                      h,
  output logic [NUM_DIGITS-1:0]     ds,
  output logic                      frame_done
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0]      div;
  logic [IDX_W-1:0]      idx;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  blink_phase;

  logic [DATA_W-1:0]     pend_data;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blink;
  logic                  pend_valid;
  logic [DATA_W-1:0]     act_data;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] act_blink;

  logic [7:0]            seg;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] ds_next;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  tick;
  logic                  wrap;
  logic [6:0]            glyph_ag;
  logic                  blanked;
  logic                  dark;

  // Segment pattern {a..g} for one nibble; 10..15 only shown when hex is enabled.
  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b1111110;
      4'h1: r = 7'b0110000;
      4'h2: r = 7'b1101101;
      4'h3: r = 7'b1111001;
      4'h4: r = 7'b0110011;
      4'h5: r = 7'b1011011;
      4'h6: r = 7'b1011111;
      4'h7: r = 7'b1110000;
      4'h8: r = 7'b1111111;
      4'h9: r = 7'b1111011;
      4'hA: r = 7'b1110111;
      4'hB: r = 7'b0011111;
      4'hC: r = 7'b1001110;
      4'hD: r = 7'b0111101;
      4'hE: r = 7'b1001111;
      default: r = 7'b1000111;
    endcase
    if (!hex && n > 4'd9) r = '0;
    return r;
  endfunction

  // Next digit's segments, computed from the active buffer and live controls.
  always_comb begin
    tick = (div == DIV_W'(CLK_DIV - 1));
    wrap = (idx == '0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib[i]       = act_data[4*i +: 4];
      lead_zero[i] = ((act_data >> (4*i)) == '0);
    end
    glyph_ag = glyph(nib[idx], hex_en);
    blanked  = blank_en && !wrap && lead_zero[idx];
    dark     = act_blink[idx] && blink_phase;
    seg_next = {glyph_ag & {7{~blanked}}, act_dp[idx]} & {8{~dark}};
    ds_next  = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div         <= '0;
      idx         <= IDX_W'(NUM_DIGITS - 1);
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_blink  <= '0;
      pend_valid  <= 1'b0;
      act_data    <= '0;
      act_dp      <= '0;
      act_blink   <= '0;
      seg         <= '0;
      ds          <= '1;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      div        <= tick ? '0 : div + 1'b1;
      if (tick) begin
        seg <= seg_next;
        ds  <= ds_next;
        if (wrap) begin
          idx        <= IDX_W'(NUM_DIGITS - 1);
          frame_done <= 1'b1;
          if (pend_valid) begin
            act_data   <= pend_data;
            act_dp     <= pend_dp;
            act_blink  <= pend_blink;
            pend_valid <= 1'b0;
          end
          if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end else begin
          idx <= idx - 1'b1;
        end
      end
      // A load on the boundary edge overrides the clear above and waits a frame.
      if (load) begin
        pend_data  <= data;
        pend_dp    <= dp;
        pend_blink <= blink_mask;
        pend_valid <= 1'b1;
      end
    end
  end

  assign {a, b, c, d, e, f, g, h} = seg;

endmodule

// File: tb/tb_seg7_scan_gen.sv
// Bench for seg7_scan_gen: directed scenarios plus random loads, checked slot by
// slot against a frame-level model of what each digit should show.
module tb_seg7_scan_gen;

  localparam int unsigned N   = 8;
  localparam int unsigned DIV = 4;
  localparam int unsigned BF  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  blink_mask = '0;
  logic        load = 1'b0;
  logic        blank_en = 1'b0;
  logic        hex_en = 1'b0;
  logic        a, b, c, d, e, f, g, h;
  logic [7:0]  ds;
  logic        frame_done;

  seg7_scan_gen #(.NUM_DIGITS(N), .CLK_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blink_mask(blink_mask),
    .load(load), .blank_en(blank_en), .hex_en(hex_en),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .ds(ds), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Model: what is displayed this frame, what is waiting, and where the scan is.
  logic [31:0] m_act_data, m_pend_data;
  logic [7:0]  m_act_dp, m_pend_dp, m_act_bm, m_pend_bm;
  bit          m_pv;
  int          m_frame;
  int          m_slot;
  logic [7:0]  m_prev_ds;

  // Pending stimulus request for the next slot.
  bit          ld_req = 1'b0;
  int          ld_edge = 0;
  logic [31:0] ld_data;
  logic [7:0]  ld_dp, ld_bm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act_data = '0; m_act_dp = '0; m_act_bm = '0;
    m_pend_data = '0; m_pend_dp = '0; m_pend_bm = '0;
    m_pv = 1'b0; m_frame = 0; m_slot = N - 1; m_prev_ds = 8'hFF;
  endtask

  function automatic logic [7:0] exp_seg(input int i);
    int         nib;
    logic [6:0] ag;
    bit         phase;
    nib   = int'((m_act_data >> (4*i)) & 32'hF);
    ag    = glyph_tab[nib][7:1];
    if (nib >= 10 && !hex_en) ag = '0;
    if (blank_en && i > 0 && (m_act_data >> (4*i)) == 32'd0) ag = '0;
    phase = ((m_frame / BF) % 2) == 1;
    if (phase && m_act_bm[i]) return 8'h00;
    return {ag, m_act_dp[i]};
  endfunction

  task automatic set_load(input logic [31:0] dv, input logic [7:0] dpv,
                          input logic [7:0] bmv, input int edge_no);
    ld_req = 1'b1; ld_data = dv; ld_dp = dpv; ld_bm = bmv; ld_edge = edge_no;
  endtask

  // One digit slot: CLK_DIV edges, outputs checked after the tick edge.
  task automatic slot();
    bit         ld_now;
    logic [7:0] exp_ds;
    for (int k = 0; k < int'(DIV); k++) begin
      ld_now = ld_req && (k == ld_edge);
      load = ld_now;
      if (ld_now) begin data = ld_data; dp = ld_dp; blink_mask = ld_bm; end
      @(posedge clk); #1;
      load = 1'b0;
      if (k == 0) check("frame_done_idle", 32'(frame_done), 32'd0);
      if (k == int'(DIV) - 2) check("ds_hold", 32'(ds), 32'(m_prev_ds));
      if (k == int'(DIV) - 1) begin
        exp_ds = ~(8'd1 << m_slot);
        check("ds", 32'(ds), 32'(exp_ds));
        check("seg", 32'({a, b, c, d, e, f, g, h}), 32'(exp_seg(m_slot)));
        check("frame_done", 32'(frame_done), (m_slot == 0) ? 32'd1 : 32'd0);
        m_prev_ds = exp_ds;
        if (m_slot == 0) begin
          if (m_pv) begin
            m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_bm = m_pend_bm;
            m_pv = 1'b0;
          end
          m_frame++;
          m_slot = N - 1;
        end else begin
          m_slot--;
        end
      end
      if (ld_now) begin
        m_pend_data = ld_data; m_pend_dp = ld_dp; m_pend_bm = ld_bm; m_pv = 1'b1;
      end
    end
    ld_req = 1'b0;
  endtask

  task automatic frame();
    repeat (N) slot();
  endtask

  initial begin
    logic [31:0] rd;
    model_reset();

    // Reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_ds", 32'(ds), 32'hFF);
    check("rst_seg", 32'({a, b, c, d, e, f, g, h}), 32'h00);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;

    // Decimal digits: first frame still shows the zero active buffer
    set_load(32'h12345678, 8'h00, 8'h00, 0);
    frame();
    frame();

    // Leading-zero blanking
    blank_en = 1'b1;
    set_load(32'h00000120, 8'h00, 8'h00, 1);
    frame();
    frame();

    // Hex glyphs, then the same digits with hex disabled
    hex_en = 1'b1;
    set_load(32'h0000ABCD, 8'h00, 8'h00, 2);
    frame();
    frame();
    hex_en = 1'b0;
    frame();

    // Two loads in one frame: current frame untouched, last load wins
    blank_en = 1'b0;
    for (int s = 0; s < int'(N); s++) begin
      if (s == 2) set_load(32'h11111111, 8'h00, 8'h00, 0);
      if (s == 5) set_load(32'h22222222, 8'h00, 8'h00, 3);
      slot();
    end
    frame();

    // Blink with decimal point on digit 0
    set_load(32'h00000003, 8'h01, 8'h01, 0);
    repeat (6) frame();

    // Load on the boundary edge itself waits one more frame
    for (int s = 0; s < int'(N); s++) begin
      if (s == int'(N) - 1) set_load(32'h98765432, 8'hA5, 8'h00, int'(DIV) - 1);
      slot();
    end
    frame();
    frame();

    // Randomized controls and loads
    for (int fr = 0; fr < 20; fr++) begin
      blank_en = 1'($urandom_range(0, 1));
      hex_en   = 1'($urandom_range(0, 1));
      for (int s = 0; s < int'(N); s++) begin
        if ($urandom_range(0, 3) == 0) begin
          rd = $urandom;
          rd = rd >> (4 * $urandom_range(0, 7));
          set_load(rd, 8'($urandom), 8'($urandom), int'($urandom_range(0, DIV - 1)));
        end
        slot();
      end
    end

    // Reset mid-frame with a load pending
    blank_en = 1'b0;
    hex_en   = 1'b0;
    repeat (3) slot();
    load = 1'b1; data = 32'hDEADBEEF; dp = 8'hFF; blink_mask = 8'h00;
    @(posedge clk); #1;
    load = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ds", 32'(ds), 32'hFF);
    check("midrst_seg", 32'({a, b, c, d, e, f, g, h}), 32'h00);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    model_reset();
    frame();
    frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
